// File: rtl/cs_window_decoder.sv
// rtl/cs_window_decoder.sv - 68000 chip-select window decoder with boot overlay and posted-write credits
//
// Purpose: registers a one-hot region select at the start of every bus cycle. A boot
// overlay maps RAM to ROM until enough ROM hits are seen. A credit counter limits the
// number of outstanding posted writes to the I/O bus.
// Optional feature macro: CS_OVERLAY_EN (overlay FSM, hit counter and RAM->ROM redirect).
//
// Ports:
//   CLK      in   system clock, rising edge
//   RES      in   asynchronous active-high reset
//   A        in   CPU address A[AW:1]; A[AW:AW-7] is decoded
//   nWE      in   low = write cycle
//   BACT     in   bus cycle active
//   QoSEN    in   high forces accesses non-posted
//   PWDONE   in   one-cycle pulse, a posted write retired
//   SEL      out  registered one-hot region select
//   MISS     out  registered, no region matched
//   OVERLAY  out  overlay state
//   POSTED   out  registered, current access is a posted write
//   CREDITS  out  free posted-write credits
module cs_window_decoder #(
    parameter int                AW          = 23,
    parameter int                NREG        = 8,
    parameter logic [8*NREG-1:0] REGION_BASE = 64'h3F_F6_F5_F4_F3_F2_40_00,
    parameter logic [8*NREG-1:0] REGION_MASK = 64'hFF_FF_FF_FF_FF_FF_F0_C0,
    parameter int                ROM_REGION  = 1,
    parameter int                RAM_REGION  = 0,
    parameter int                OVL_HITS    = 1,
    parameter logic [NREG-1:0]   PW_MASK     = 8'h80,
    parameter int                PW_DEPTH    = 2
) (
    input  logic            CLK,
    input  logic            RES,
    input  logic [AW:1]     A,
    input  logic            nWE,
    input  logic            BACT,
    input  logic            QoSEN,
    input  logic            PWDONE,
    output logic [NREG-1:0] SEL,
    output logic            MISS,
    output logic            OVERLAY,
    output logic            POSTED,
    output logic [2:0]      CREDITS
);

    localparam int         IW    = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [2:0] DEPTH = 3'(PW_DEPTH);

    logic [NREG-1:0] match;
    logic            hit;
    logic [IW-1:0]   win;
    logic [IW-1:0]   eff_win;
    logic            ovl_active;
    logic            cap;
    logic            posted_d;
    logic            take;
    logic            give;

    logic            bact_q;
    logic [NREG-1:0] sel_q;
    logic            miss_q;
    logic            posted_q;
    logic [2:0]      credits_q;

    // Priority decode: scanning from the top down leaves the lowest matching index.
    always_comb begin
        match = '0;
        hit   = 1'b0;
        win   = '0;
        for (int i = 0; i < NREG; i++) begin
            match[i] = ((A[AW -: 8] & REGION_MASK[8*i +: 8]) ==
                        (REGION_BASE[8*i +: 8] & REGION_MASK[8*i +: 8]));
        end
        for (int i = NREG - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit = 1'b1;
                win = IW'(i);
            end
        end
    end

    // bact_q resets high so a BACT still asserted when RES drops is not taken as a new cycle.
    assign cap = BACT && !bact_q;

    always_comb begin
        eff_win = win;
        if (ovl_active && hit && (win == IW'(RAM_REGION))) begin
            eff_win = IW'(ROM_REGION);
        end
    end

    assign posted_d = hit && !nWE && PW_MASK[eff_win] && !QoSEN && (credits_q != 3'd0);
    assign take     = cap && posted_d;
    // A retire with every credit already free is spurious and dropped.
    assign give     = PWDONE && (credits_q != DEPTH);

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            bact_q    <= 1'b1;
            sel_q     <= '0;
            miss_q    <= 1'b0;
            posted_q  <= 1'b0;
            credits_q <= DEPTH;
        end else begin
            bact_q <= BACT;
            if (!BACT) begin
                sel_q    <= '0;
                miss_q   <= 1'b0;
                posted_q <= 1'b0;
            end else if (cap) begin
                sel_q    <= hit ? (NREG'(1) << eff_win) : '0;
                miss_q   <= !hit;
                posted_q <= posted_d;
            end
            if (take && !give) begin
                credits_q <= credits_q - 3'd1;
            end else if (give && !take) begin
                credits_q <= credits_q + 3'd1;
            end
        end
    end

`ifdef CS_OVERLAY_EN
    typedef enum logic {
        OVL = 1'b0,
        RUN = 1'b1
    } ovl_state_t;

    ovl_state_t state_q;
    ovl_state_t state_d;
    logic [3:0] hits_q;
    logic [3:0] hits_d;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q <= OVL;
            hits_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            hits_q  <= hits_d;
        end
    end

    // ROM hits are counted on the un-redirected winner, so overlaid RAM accesses do not count.
    always_comb begin
        state_d = state_q;
        hits_d  = hits_q;
        if ((state_q == OVL) && cap && hit && (win == IW'(ROM_REGION))) begin
            hits_d = hits_q + 4'd1;
            if (hits_d == 4'(OVL_HITS)) begin
                state_d = RUN;
            end
        end
    end

    assign ovl_active = (state_q == OVL);
`else
    assign ovl_active = 1'b0;
`endif

    assign SEL     = sel_q;
    assign MISS    = miss_q;
    assign POSTED  = posted_q;
    assign CREDITS = credits_q;
    assign OVERLAY = ovl_active;

endmodule

// File: tb/tb_cs_window_decoder.sv
// tb/tb_cs_window_decoder.sv - directed self-checking bench for cs_window_decoder
module tb_cs_window_decoder;

`ifdef CS_OVERLAY_EN
    localparam bit OE = 1'b1;
`else
    localparam bit OE = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic [23:1] A = '0;
    logic        nWE = 1'b1;
    logic        BACT = 1'b0;
    logic        QoSEN = 1'b0;
    logic        PWDONE = 1'b0;

    logic [7:0] sel_a, sel_v;
    logic       miss_a, miss_v, ovl_a, ovl_v, posted_a, posted_v;
    logic [2:0] credits_a, credits_v;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // Bench configuration: RAM 0, ROM 1, video 7 (shadowed by RAM's wide mask).
    cs_window_decoder #(
        .AW(23), .NREG(8),
        .REGION_BASE(64'h3F_F6_F5_F4_F3_F2_40_00),
        .REGION_MASK(64'hFF_FF_FF_FF_FF_FF_F0_C0),
        .ROM_REGION(1), .RAM_REGION(0), .OVL_HITS(1),
        .PW_MASK(8'h80), .PW_DEPTH(2)
    ) u_dut (
        .CLK(CLK), .RES(RES), .A(A), .nWE(nWE), .BACT(BACT), .QoSEN(QoSEN),
        .PWDONE(PWDONE), .SEL(sel_a), .MISS(miss_a), .OVERLAY(ovl_a),
        .POSTED(posted_a), .CREDITS(credits_a)
    );

    // Reprogrammed copy: video at index 0, ROM 1, RAM 2.
    cs_window_decoder #(
        .AW(23), .NREG(8),
        .REGION_BASE(64'hF7_F6_F5_F4_F3_00_40_3F),
        .REGION_MASK(64'hFF_FF_FF_FF_FF_C0_F0_FF),
        .ROM_REGION(1), .RAM_REGION(2), .OVL_HITS(1),
        .PW_MASK(8'h01), .PW_DEPTH(2)
    ) u_dut_v (
        .CLK(CLK), .RES(RES), .A(A), .nWE(nWE), .BACT(BACT), .QoSEN(QoSEN),
        .PWDONE(PWDONE), .SEL(sel_v), .MISS(miss_v), .OVERLAY(ovl_v),
        .POSTED(posted_v), .CREDITS(credits_v)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Raise BACT with an address; returns at the next falling edge, after the capture edge.
    task automatic start_access(input logic [23:1] addr, input logic we_n, input logic pwd);
        @(negedge CLK);
        A = addr;
        nWE = we_n;
        BACT = 1'b1;
        PWDONE = pwd;
        @(negedge CLK);
        PWDONE = 1'b0;
    endtask

    task automatic end_access();
        BACT = 1'b0;
        nWE = 1'b1;
        @(negedge CLK);
    endtask

    task automatic pulse_pwdone();
        @(negedge CLK);
        PWDONE = 1'b1;
        @(negedge CLK);
        PWDONE = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_sel", 32'(sel_a), 32'h00);
        check("rst_miss", 32'(miss_a), 32'h0);
        check("rst_posted", 32'(posted_a), 32'h0);
        check("rst_credits", 32'(credits_a), 32'h2);
        check("rst_overlay", 32'(ovl_a), 32'(OE));
        RES = 1'b0;

        // Overlay: RAM read redirected to ROM, then a ROM read leaves overlay.
        start_access(23'h000000, 1'b1, 1'b0);
        check("ovl_ram_sel", 32'(sel_a), OE ? 32'h02 : 32'h01);
        check("ovl_ram_sel_v", 32'(sel_v), OE ? 32'h02 : 32'h04);
        check("ovl_ram_overlay", 32'(ovl_a), 32'(OE));
        A = 23'h500000;
        @(negedge CLK);
        check("hold_sel", 32'(sel_a), OE ? 32'h02 : 32'h01);
        end_access();
        check("clear_sel", 32'(sel_a), 32'h00);

        start_access(23'h200000, 1'b1, 1'b0);
        check("rom_sel", 32'(sel_a), 32'h02);
        check("rom_overlay_exit", 32'(ovl_a), 32'h0);
        end_access();

        start_access(23'h000000, 1'b1, 1'b0);
        check("run_ram_sel", 32'(sel_a), 32'h01);
        check("run_ram_sel_v", 32'(sel_v), 32'h04);
        end_access();

        // Video write: shadowed by RAM in the bench config, posted in the reprogrammed copy.
        start_access(23'h1F8000, 1'b0, 1'b0);
        check("vid_sel", 32'(sel_a), 32'h01);
        check("vid_posted", 32'(posted_a), 32'h0);
        check("vid_credits", 32'(credits_a), 32'h2);
        check("vid_sel_v", 32'(sel_v), 32'h01);
        check("vid_posted_v", 32'(posted_v), 32'h1);
        check("vid_credits_v", 32'(credits_v), 32'h1);
        end_access();
        pulse_pwdone();
        check("pwd_restore", 32'(credits_v), 32'h2);

        // Three eligible writes with no retire: the third runs out of credits.
        for (int i = 0; i < 3; i++) begin
            start_access(23'h1F8000, 1'b0, 1'b0);
            check($sformatf("burst_posted%0d", i), 32'(posted_v), (i < 2) ? 32'h1 : 32'h0);
            check($sformatf("burst_credits%0d", i), 32'(credits_v), (i == 0) ? 32'h1 : 32'h0);
            end_access();
        end

        // Posted capture coinciding with a retire leaves credits unchanged.
        pulse_pwdone();
        check("pwd_one", 32'(credits_v), 32'h1);
        start_access(23'h1F8000, 1'b0, 1'b1);
        check("same_edge_posted", 32'(posted_v), 32'h1);
        check("same_edge_credits", 32'(credits_v), 32'h1);
        end_access();
        pulse_pwdone();
        check("pwd_two", 32'(credits_v), 32'h2);
        pulse_pwdone();
        check("pwd_saturate", 32'(credits_v), 32'h2);

        // QoS forces non-posted.
        QoSEN = 1'b1;
        start_access(23'h1F8000, 1'b0, 1'b0);
        check("qos_posted", 32'(posted_v), 32'h0);
        check("qos_credits", 32'(credits_v), 32'h2);
        end_access();
        QoSEN = 1'b0;

        // Unmapped address.
        start_access(23'h500000, 1'b1, 1'b0);
        check("miss_flag", 32'(miss_a), 32'h1);
        check("miss_sel", 32'(sel_a), 32'h00);
        check("miss_flag_v", 32'(miss_v), 32'h1);
        end_access();

        // Reset in the middle of a posted access.
        start_access(23'h1F8000, 1'b0, 1'b0);
        check("pre_rst_posted", 32'(posted_v), 32'h1);
        #2 RES = 1'b1;
        #1;
        check("async_rst_sel", 32'(sel_v), 32'h00);
        check("async_rst_posted", 32'(posted_v), 32'h0);
        check("async_rst_credits", 32'(credits_v), 32'h2);
        check("async_rst_overlay", 32'(ovl_a), 32'(OE));
        @(negedge CLK);
        RES = 1'b0;
        A = 23'h000000;
        nWE = 1'b1;
        repeat (2) @(negedge CLK);
        check("no_cap_after_rst", 32'(sel_a), 32'h00);
        end_access();
        start_access(23'h000000, 1'b1, 1'b0);
        check("recap_sel", 32'(sel_a), OE ? 32'h02 : 32'h01);
        end_access();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
